pwm_button_conditioner: RTL

//   Conditions the two raw duty-adjust buttons (up/down) before they reach pwm_signal_generator.
//   Per button: 2-flop synchroniser, counter debouncer, single-cycle press pulse, auto-repeat while held.
//   xu_pulse/xd_pulse drive the generator's xu/xd inputs directly: one duty step per pulse.

---
 rtl/pwm_button_conditioner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pwm_button_conditioner.sv
// Conditions the raw up/down duty buttons: synchronise, debounce, one-cycle press pulse
// and auto-repeat while held, with mutual lockout when both buttons are down.
module pwm_button_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEB_CYCLES   = 16,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic xu_raw,
    input  logic xd_raw,
    output logic xu_pulse,
    output logic xd_pulse,
    output logic xu_level,
    output logic xd_level
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    // Channel 0 is up, channel 1 is down.
    logic [1:0]             raw_s;
    logic [SYNC_STAGES-1:0] sync_r      [2];
    logic [CNT_W-1:0]       deb_cnt_r   [2];
    logic [CNT_W-1:0]       deb_cnt_nxt_s [2];
    logic [1:0]             level_r;
    logic [1:0]             level_nxt_s;
    logic [1:0]             rise_s;
    logic                   lockout_s;
    state_t                 state_r     [2];
    logic [CNT_W-1:0]       rep_cnt_r   [2];
    logic [1:0]             pulse_r;

    assign raw_s = {xd_raw, xu_raw};

    // Next debounced level and debounce count for both channels.
    always_comb begin
        level_nxt_s = level_r;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_nxt_s[i] = deb_cnt_r[i];
            if (sync_r[i][SYNC_STAGES-1] != level_r[i]) begin
                if (deb_cnt_r[i] >= DEB_LAST) begin
                    level_nxt_s[i]   = sync_r[i][SYNC_STAGES-1];
                    deb_cnt_nxt_s[i] = CNT_ZERO;
                end else begin
                    deb_cnt_nxt_s[i] = sat_inc(deb_cnt_r[i]);
                end
            end else begin
                deb_cnt_nxt_s[i] = CNT_ZERO;
            end
        end
    end

    // The FSMs look at the level being registered this cycle so the first pulse
    // leaves together with the rising level.
    assign rise_s    = level_nxt_s & ~level_r;
    assign lockout_s = level_nxt_s[0] & level_nxt_s[1];

    // Synchroniser chains, debounce counters and debounced levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i]    <= {SYNC_STAGES{1'b0}};
                deb_cnt_r[i] <= CNT_ZERO;
            end
            level_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i]    <= {sync_r[i][SYNC_STAGES-2:0], raw_s[i]};
                deb_cnt_r[i] <= deb_cnt_nxt_s[i];
            end
            level_r <= level_nxt_s;
        end
    end

    // Press / auto-repeat FSM per channel with registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i]   <= ST_IDLE;
                rep_cnt_r[i] <= CNT_ZERO;
            end
            pulse_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!level_nxt_s[i] || !ena || lockout_s) begin
                    state_r[i]   <= ST_IDLE;
                    rep_cnt_r[i] <= CNT_ZERO;
                    pulse_r[i]   <= 1'b0;
                end else begin
                    case (state_r[i])
                        ST_IDLE: begin
                            rep_cnt_r[i] <= CNT_ZERO;
                            pulse_r[i]   <= rise_s[i];
                            state_r[i]   <= rise_s[i] ? ST_HOLD_WAIT : ST_IDLE;
                        end
                        ST_HOLD_WAIT: begin
                            if (rep_cnt_r[i] >= DELAY_LAST) begin
                                rep_cnt_r[i] <= CNT_ZERO;
                                pulse_r[i]   <= 1'b1;
                                state_r[i]   <= ST_REPEAT;
                            end else begin
                                rep_cnt_r[i] <= sat_inc(rep_cnt_r[i]);
                                pulse_r[i]   <= 1'b0;
                                state_r[i]   <= ST_HOLD_WAIT;
                            end
                        end
                        ST_REPEAT: begin
                            if (rep_cnt_r[i] >= RATE_LAST) begin
                                rep_cnt_r[i] <= CNT_ZERO;
                                pulse_r[i]   <= 1'b1;
                            end else begin
                                rep_cnt_r[i] <= sat_inc(rep_cnt_r[i]);
                                pulse_r[i]   <= 1'b0;
                            end
                            state_r[i] <= ST_REPEAT;
                        end
                        default: begin
                            state_r[i]   <= ST_IDLE;
                            rep_cnt_r[i] <= CNT_ZERO;
                            pulse_r[i]   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign xu_pulse = pulse_r[0];
    assign xd_pulse = pulse_r[1];
    assign xu_level = level_r[0];
    assign xd_level = level_r[1];

endmodule
